// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared types and constants for the hex scanner.
// Segment table is stored with bit0 = segment a.
package hex_display_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_e;

   localparam int DIGIT_SEP_IDX = 2;

   // Index n holds the active-high abcdefg pattern for hex digit n.
   localparam logic [15:0][6:0] HEXSEG = {
      7'h71, 7'h79, 7'h5E, 7'h39,
      7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66,
      7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/hex_display_scan_decode.sv
// hex7seg_decode: 4-bit nibble to active-high 7-segment pattern.
// Reusable by any other hex readout.
module hex7seg_decode
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   // Pure table lookup, bit0 = segment a.
   assign seg_o = HEXSEG[nibble_i];

endmodule

// File: rtl/hex_display_scan.sv
// hex_display_scan: 4-digit multiplexed common-anode scanner.
// odev1 on the left two digits, odev0 on the right two.
module hex_display_scan
   import hex_display_pkg::*;
#(
   parameter int DWELL_CYCLES = 1024,
   parameter int BLANK_CYCLES = 16,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] dev1_data,
   input  logic [7:0] dev0_data,
   output logic [6:0] seg_b,
   output logic       dp_b,
   output logic [3:0] digit_b,
   output logic       frame_done
);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [1:0]       SEP_IDX    = 2'(DIGIT_SEP_IDX);

   state_e           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      snap_q, snap_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       dig_q, dig_d;
   logic             fd_q, fd_d;
   logic [3:0]       nibble;
   logic [6:0]       seg_hi;
   logic             show;

   // Outputs follow the state being entered, so decode the next snapshot.
   assign nibble = snap_d[{idx_d, 2'b00} +: 4];

   hex7seg_decode u_dec (
      .nibble_i (nibble),
      .seg_o    (seg_hi)
   );

   // Next-state: blank/show sequencing with idx0 snapshot.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + CNT_W'(1);
      snap_d  = snap_q;
      fd_d    = 1'b0;
      if (!en) begin
         state_d = BLANK;
         idx_d   = 2'd0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  cnt_d   = '0;
                  state_d = SHOW;
                  if (idx_q == 2'd0) begin
                     snap_d = {dev1_data, dev0_data};
                  end
               end
            end
            SHOW: begin
               if (cnt_q == DWELL_LAST) begin
                  cnt_d   = '0;
                  state_d = BLANK;
                  idx_d   = idx_q + 2'd1;
                  fd_d    = (idx_q == 2'd3);
               end
            end
            default: state_d = BLANK;
         endcase
      end
   end

   // Output decode for the entered state; blank drives nothing.
   always_comb begin
      show  = (state_d == SHOW);
      dig_d = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (show) begin
         dig_d = ~(4'b0001 << idx_d);
         seg_d = ~seg_hi;
         dp_d  = (idx_d != SEP_IDX);
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BLANK;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         snap_q  <= 16'h0000;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         dig_q   <= 4'hF;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         dig_q   <= dig_d;
         fd_q    <= fd_d;
      end
   end

   assign seg_b      = seg_q;
   assign dp_b       = dp_q;
   assign digit_b    = dig_q;
   assign frame_done = fd_q;

endmodule
